fb_write_arbiter: RTL and testbench

- Sequences and shares the single framebuffer pixel-write port (x, y, pixel_GS, pixel_write) between two pixel producers.
- Also contains a built-in full-screen clear engine.
- Sits between the drawing/image-processing logic and VGA_framebuffer, on the same clk50 domain.
- Arbitrates round-robin between two valid/ready requesters, drops off-screen writes, and on command sweeps all 640x480 pixels with a fill value.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_write_arbiter_if.sv | 50 +++++
 rtl/rr_arb2.sv | 29 ++
 rtl/fb_write_arbiter.sv | 110 +++++++++++
 tb/tb_fb_write_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and types for the framebuffer write path
package fb_pkg;

  localparam int HRES = 640;
  localparam int VRES = 480;
  localparam int XW   = 11;
  localparam int PW   = 8;
  localparam int CW   = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [PW-1:0] pixel;
  } fb_wr_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - requester, clear and framebuffer write signals
interface fb_write_arbiter_if #(
  parameter int CW = fb_pkg::CW
);
  import fb_pkg::*;

  logic          req0_valid;
  logic [XW-1:0] req0_x;
  logic [XW-1:0] req0_y;
  logic [PW-1:0] req0_pixel;
  logic          req0_ready;

  logic          req1_valid;
  logic [XW-1:0] req1_x;
  logic [XW-1:0] req1_y;
  logic [PW-1:0] req1_pixel;
  logic          req1_ready;

  logic          clear_start;
  logic [PW-1:0] clear_value;
  logic          clear_busy;
  logic          clear_done;

  logic [XW-1:0] x;
  logic [XW-1:0] y;
  logic [PW-1:0] pixel_GS;
  logic          pixel_write;
  logic [CW-1:0] drop_count;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_pixel,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_pixel,
    output req1_ready,
    input  clear_start, clear_value,
    output clear_busy, clear_done,
    output x, y, pixel_GS, pixel_write, drop_count
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_pixel,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_pixel,
    input  req1_ready,
    output clear_start, clear_value,
    input  clear_busy, clear_done,
    input  x, y, pixel_GS, pixel_write, drop_count
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter owning the last-grant pointer
module rr_arb2 (
  input  logic       clk50,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  // The pointer only moves when a contended grant is actually taken.
  always_ff @(posedge clk50) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (req == 2'b11)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - shares the framebuffer write port between two producers and a clear engine
module fb_write_arbiter #(
  parameter int HRES = fb_pkg::HRES,
  parameter int VRES = fb_pkg::VRES,
  parameter int CW   = fb_pkg::CW
) (
  input logic               clk50,
  input logic               reset,
  fb_write_arbiter_if.slave bus
);
  import fb_pkg::*;

  localparam logic [XW-1:0] X_LIM  = XW'(HRES);
  localparam logic [XW-1:0] Y_LIM  = XW'(VRES);
  localparam logic [XW-1:0] X_LAST = XW'(HRES - 1);
  localparam logic [XW-1:0] Y_LAST = XW'(VRES - 1);

  fb_state_t     state;
  logic [XW-1:0] cx;
  logic [XW-1:0] cy;
  logic [PW-1:0] fill_reg;
  logic [1:0]    req;
  logic [1:0]    grant;
  logic          idle;
  logic          sel_in_range;
  logic          clear_last;
  fb_wr_t        sel;

  assign idle = (state == IDLE);
  assign req  = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk50   (clk50),
    .reset   (reset),
    .req     (req),
    .advance (idle),
    .grant   (grant)
  );

  assign bus.req0_ready = idle & grant[0];
  assign bus.req1_ready = idle & grant[1];
  assign bus.clear_busy = (state == CLEAR);

  // Payload of whichever requester holds the grant this cycle.
  always_comb begin
    sel = '{x: bus.req0_x, y: bus.req0_y, pixel: bus.req0_pixel};
    if (grant[1]) begin
      sel = '{x: bus.req1_x, y: bus.req1_y, pixel: bus.req1_pixel};
    end
  end

  assign sel_in_range = (sel.x < X_LIM) && (sel.y < Y_LIM);
  assign clear_last   = (cx == X_LAST) && (cy == Y_LAST);

  // Mode FSM, clear sweep counters, registered write port and drop counter.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state           <= IDLE;
      cx              <= '0;
      cy              <= '0;
      fill_reg        <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.pixel_GS    <= '0;
      bus.pixel_write <= 1'b0;
      bus.clear_done  <= 1'b0;
      bus.drop_count  <= '0;
    end else begin
      bus.pixel_write <= 1'b0;
      bus.clear_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            if (sel_in_range) begin
              bus.x           <= sel.x;
              bus.y           <= sel.y;
              bus.pixel_GS    <= sel.pixel;
              bus.pixel_write <= 1'b1;
            end else if (bus.drop_count != '1) begin
              bus.drop_count <= bus.drop_count + CW'(1);
            end
          end
          if (bus.clear_start) begin
            state    <= CLEAR;
            fill_reg <= bus.clear_value;
            cx       <= '0;
            cy       <= '0;
          end
        end
        CLEAR: begin
          bus.x           <= cx;
          bus.y           <= cy;
          bus.pixel_GS    <= fill_reg;
          bus.pixel_write <= 1'b1;
          if (clear_last) begin
            bus.clear_done <= 1'b1;
            state          <= IDLE;
          end else if (cx == X_LAST) begin
            cx <= '0;
            cy <= cy + XW'(1);
          end else begin
            cx <= cx + XW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int TH   = 40;
  localparam int TV   = 30;
  localparam int TCW  = 4;
  localparam int N    = TH * TV;
  localparam int DMAX = (1 << TCW) - 1;

  logic clk50 = 1'b0;
  logic reset = 1'b0;

  always #10 clk50 = ~clk50;

  fb_write_arbiter_if #(.CW(TCW)) bus ();

  fb_write_arbiter #(.HRES(TH), .VRES(TV), .CW(TCW)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int model_last = 1;
  int model_drop = 0;

  task automatic drive_idle;
    bus.req0_valid  = 1'b0;
    bus.req0_x      = '0;
    bus.req0_y      = '0;
    bus.req0_pixel  = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_x      = '0;
    bus.req1_y      = '0;
    bus.req1_pixel  = '0;
    bus.clear_start = 1'b0;
    bus.clear_value = '0;
  endtask

  task automatic do_reset;
    @(negedge clk50);
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk50);
    @(negedge clk50);
    reset = 1'b0;
    model_last = 1;
    model_drop = 0;
  endtask

  task automatic model_arb(input bit v0, input bit v1, output int g);
    if (v0 && v1) begin
      g = (model_last == 0) ? 1 : 0;
      model_last = g;
    end else if (v0) begin
      g = 0;
    end else if (v1) begin
      g = 1;
    end else begin
      g = -1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk50);
    reset = 1'b1;
    bus.req0_valid  = 1'b1;
    bus.req0_x      = 11'd4;
    bus.req0_y      = 11'd0;
    bus.req0_pixel  = 8'd99;
    bus.clear_start = 1'b1;
    bus.clear_value = 8'hAA;
    @(posedge clk50);
    #1;
    n_total++; if (bus.pixel_write !== 1'b0) $display("FAIL reset_pixel_write: got %b want 0", bus.pixel_write); else n_pass++;
    n_total++; if (bus.x !== 11'd0) $display("FAIL reset_x: got %0d want 0", bus.x); else n_pass++;
    n_total++; if (bus.y !== 11'd0) $display("FAIL reset_y: got %0d want 0", bus.y); else n_pass++;
    n_total++; if (bus.pixel_GS !== 8'd0) $display("FAIL reset_pixel_GS: got %0d want 0", bus.pixel_GS); else n_pass++;
    n_total++; if (bus.clear_busy !== 1'b0) $display("FAIL reset_clear_busy: got %b want 0", bus.clear_busy); else n_pass++;
    n_total++; if (bus.clear_done !== 1'b0) $display("FAIL reset_clear_done: got %b want 0", bus.clear_done); else n_pass++;
    n_total++; if (bus.drop_count !== 4'd0) $display("FAIL reset_drop_count: got %0d want 0", bus.drop_count); else n_pass++;
    @(negedge clk50);
    reset = 1'b0;
    drive_idle();
    model_last = 1;
    model_drop = 0;
  endtask

  task automatic test_single;
    @(negedge clk50);
    bus.req0_valid = 1'b1;
    bus.req0_x     = 11'd4;
    bus.req0_y     = 11'd0;
    bus.req0_pixel = 8'd127;
    #1;
    n_total++; if (bus.req0_ready !== 1'b1) $display("FAIL single_ready0: got %b want 1", bus.req0_ready); else n_pass++;
    n_total++; if (bus.req1_ready !== 1'b0) $display("FAIL single_ready1: got %b want 0", bus.req1_ready); else n_pass++;
    @(posedge clk50);
    #1;
    n_total++;
    if (bus.pixel_write !== 1'b1 || bus.x !== 11'd4 || bus.y !== 11'd0 || bus.pixel_GS !== 8'd127)
      $display("FAIL single_write: got we=%b (%0d,%0d)=%0d want we=1 (4,0)=127", bus.pixel_write, bus.x, bus.y, bus.pixel_GS);
    else n_pass++;
    @(negedge clk50);
    drive_idle();
  endtask

  task automatic test_alternate;
    int g;
    int ex;
    int ep;
    @(negedge clk50);
    bus.req0_valid = 1'b1; bus.req0_x = 11'd10; bus.req0_y = 11'd2; bus.req0_pixel = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_x = 11'd20; bus.req1_y = 11'd3; bus.req1_pixel = 8'h22;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk50);
      #1;
      model_arb(1'b1, 1'b1, g);
      n_total++; if (g !== (i % 2)) $display("FAIL alt_model_order: got %0d want %0d", g, i % 2); else n_pass++;
      n_total++;
      if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1))
        $display("FAIL alt_grant%0d: got r0=%b r1=%b want grant %0d", i, bus.req0_ready, bus.req1_ready, g);
      else n_pass++;
      @(posedge clk50);
      #1;
      ex = (g == 0) ? 10 : 20;
      ep = (g == 0) ? 8'h11 : 8'h22;
      n_total++;
      if (bus.pixel_write !== 1'b1 || bus.x !== ex || bus.pixel_GS !== ep)
        $display("FAIL alt_write%0d: got we=%b x=%0d pix=%0h want we=1 x=%0d pix=%0h", i, bus.pixel_write, bus.x, bus.pixel_GS, ex, ep);
      else n_pass++;
    end
    @(negedge clk50);
    drive_idle();
  endtask

  task automatic test_drop;
    int xs [3] = '{TH, 5, 2047};
    int ys [3] = '{10, TV, 3};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk50);
      bus.req1_valid = 1'b1;
      bus.req1_x     = 11'(xs[i]);
      bus.req1_y     = 11'(ys[i]);
      bus.req1_pixel = 8'h77;
      #1;
      n_total++; if (bus.req1_ready !== 1'b1) $display("FAIL drop_ready%0d: got %b want 1", i, bus.req1_ready); else n_pass++;
      @(posedge clk50);
      #1;
      n_total++; if (bus.pixel_write !== 1'b0) $display("FAIL drop_nowrite%0d: got %b want 0", i, bus.pixel_write); else n_pass++;
      n_total++; if (bus.drop_count !== 4'(i + 1)) $display("FAIL drop_count%0d: got %0d want %0d", i, bus.drop_count, i + 1); else n_pass++;
    end
    @(negedge clk50);
    drive_idle();
  endtask

  task automatic test_saturate;
    int expd;
    expd = 3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk50);
      bus.req0_valid = 1'b1;
      bus.req0_x     = 11'($urandom_range(0, TH - 1));
      bus.req0_y     = 11'($urandom_range(TV, 2047));
      @(posedge clk50);
      #1;
      expd = (expd >= DMAX) ? DMAX : expd + 1;
      n_total++; if (bus.drop_count !== 4'(expd)) $display("FAIL sat_count%0d: got %0d want %0d", i, bus.drop_count, expd); else n_pass++;
    end
    @(negedge clk50);
    drive_idle();
  endtask

  task automatic test_clear;
    int bad;
    int ready_bad;
    int done_cnt;
    int ex;
    int ey;
    string first;
    bad = 0; ready_bad = 0; done_cnt = 0; first = "";
    @(negedge clk50);
    bus.clear_start = 1'b1;
    bus.clear_value = 8'h20;
    #1;
    n_total++; if (bus.clear_busy !== 1'b0) $display("FAIL clr_busy_early: got %b want 0", bus.clear_busy); else n_pass++;
    @(posedge clk50);
    #1;
    n_total++; if (bus.clear_busy !== 1'b1) $display("FAIL clr_busy_start: got %b want 1", bus.clear_busy); else n_pass++;
    n_total++; if (bus.pixel_write !== 1'b0) $display("FAIL clr_no_early_write: got %b want 0", bus.pixel_write); else n_pass++;
    for (int k = 0; k < N; k++) begin
      @(negedge clk50);
      if (k == 0) begin
        bus.clear_start = 1'b0;
        bus.req0_valid  = 1'b1;
        bus.req0_x      = 11'd1;
        bus.req0_y      = 11'd1;
        bus.req0_pixel  = 8'hEE;
      end
      #1;
      if (bus.req0_ready !== 1'b0 || bus.clear_busy !== 1'b1) ready_bad++;
      if (k == N - 1) bus.req0_valid = 1'b0;
      @(posedge clk50);
      #1;
      ex = k % TH;
      ey = k / TH;
      if (bus.clear_done === 1'b1) done_cnt++;
      if (bus.pixel_write !== 1'b1 || bus.x !== ex || bus.y !== ey || bus.pixel_GS !== 8'h20 ||
          bus.clear_done !== (k == N - 1)) begin
        if (bad == 0)
          first = $sformatf("write %0d got we=%b (%0d,%0d)=%0h done=%b want (%0d,%0d)=20", k,
                            bus.pixel_write, bus.x, bus.y, bus.pixel_GS, bus.clear_done, ex, ey);
        bad++;
      end
    end
    n_total++; if (bad !== 0) $display("FAIL clr_sweep: %0d bad writes, first %s", bad, first); else n_pass++;
    n_total++; if (ready_bad !== 0) $display("FAIL clr_ready_blocked: got %0d bad cycles want 0", ready_bad); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL clr_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (bus.clear_busy !== 1'b0) $display("FAIL clr_busy_end: got %b want 0", bus.clear_busy); else n_pass++;
    @(posedge clk50);
    #1;
    n_total++;
    if (bus.pixel_write !== 1'b0 || bus.clear_done !== 1'b0)
      $display("FAIL clr_after: got we=%b done=%b want 0 0", bus.pixel_write, bus.clear_done);
    else n_pass++;
    @(negedge clk50);
    drive_idle();
  endtask

  task automatic test_clear_with_req;
    int bad;
    int done_cnt;
    string first;
    bad = 0; done_cnt = 0; first = "";
    @(negedge clk50);
    bus.clear_start = 1'b1;
    bus.clear_value = 8'h5A;
    bus.req1_valid  = 1'b1;
    bus.req1_x      = 11'd7;
    bus.req1_y      = 11'd3;
    bus.req1_pixel  = 8'h55;
    #1;
    n_total++; if (bus.req1_ready !== 1'b1) $display("FAIL cwr_ready1: got %b want 1", bus.req1_ready); else n_pass++;
    @(posedge clk50);
    #1;
    n_total++;
    if (bus.pixel_write !== 1'b1 || bus.x !== 11'd7 || bus.y !== 11'd3 || bus.pixel_GS !== 8'h55)
      $display("FAIL cwr_req_write: got we=%b (%0d,%0d)=%0h want (7,3)=55", bus.pixel_write, bus.x, bus.y, bus.pixel_GS);
    else n_pass++;
    for (int k = 0; k < N; k++) begin
      if (k == 0) begin
        @(negedge clk50);
        drive_idle();
      end
      @(posedge clk50);
      #1;
      if (bus.clear_done === 1'b1) done_cnt++;
      if (bus.pixel_write !== 1'b1 || bus.x !== (k % TH) || bus.y !== (k / TH) || bus.pixel_GS !== 8'h5A) begin
        if (bad == 0)
          first = $sformatf("write %0d got we=%b (%0d,%0d)=%0h want (%0d,%0d)=5a", k,
                            bus.pixel_write, bus.x, bus.y, bus.pixel_GS, k % TH, k / TH);
        bad++;
      end
    end
    n_total++; if (bad !== 0) $display("FAIL cwr_sweep: %0d bad writes, first %s", bad, first); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL cwr_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (bus.clear_done !== 1'b1) $display("FAIL cwr_done_last: got %b want 1", bus.clear_done); else n_pass++;
  endtask

  task automatic test_reset_mid_clear;
    int bad;
    string first;
    bad = 0; first = "";
    @(negedge clk50);
    drive_idle();
    bus.clear_start = 1'b1;
    bus.clear_value = 8'h33;
    @(posedge clk50);
    @(negedge clk50);
    bus.clear_start = 1'b0;
    for (int k = 0; k <= 1000; k++) begin
      @(posedge clk50);
      #1;
      if (bus.pixel_write !== 1'b1 || bus.x !== (k % TH) || bus.y !== (k / TH) || bus.pixel_GS !== 8'h33) begin
        if (bad == 0)
          first = $sformatf("write %0d got (%0d,%0d)=%0h", k, bus.x, bus.y, bus.pixel_GS);
        bad++;
      end
    end
    n_total++; if (bad !== 0) $display("FAIL rmc_prefix: %0d bad writes, first %s", bad, first); else n_pass++;
    @(negedge clk50);
    reset = 1'b1;
    @(posedge clk50);
    #1;
    n_total++; if (bus.clear_busy !== 1'b0) $display("FAIL rmc_busy: got %b want 0", bus.clear_busy); else n_pass++;
    n_total++; if (bus.pixel_write !== 1'b0) $display("FAIL rmc_write: got %b want 0", bus.pixel_write); else n_pass++;
    n_total++; if (bus.clear_done !== 1'b0) $display("FAIL rmc_done: got %b want 0", bus.clear_done); else n_pass++;
    @(negedge clk50);
    reset = 1'b0;
    model_last = 1;
    model_drop = 0;
    bus.clear_start = 1'b1;
    bus.clear_value = 8'h44;
    @(posedge clk50);
    @(negedge clk50);
    bus.clear_start = 1'b0;
    @(posedge clk50);
    #1;
    n_total++;
    if (bus.pixel_write !== 1'b1 || bus.x !== 11'd0 || bus.y !== 11'd0 || bus.pixel_GS !== 8'h44)
      $display("FAIL rmc_restart: got we=%b (%0d,%0d)=%0h want (0,0)=44", bus.pixel_write, bus.x, bus.y, bus.pixel_GS);
    else n_pass++;
    repeat (N - 1) @(posedge clk50);
    #1;
    n_total++;
    if (bus.clear_done !== 1'b1 || bus.x !== 11'(TH - 1) || bus.y !== 11'(TV - 1))
      $display("FAIL rmc_finish: got done=%b (%0d,%0d) want done=1 (%0d,%0d)", bus.clear_done, bus.x, bus.y, TH - 1, TV - 1);
    else n_pass++;
  endtask

  task automatic test_random;
    bit v0, v1, hold0, hold1;
    int px [2];
    int py [2];
    int pp [2];
    int g;
    bit exp_we;
    do_reset();
    hold0 = 0; hold1 = 0; v0 = 0; v1 = 0;
    px = '{0, 0}; py = '{0, 0}; pp = '{0, 0};
    for (int c = 0; c < 300; c++) begin
      @(negedge clk50);
      for (int r = 0; r < 2; r++) begin
        if (!(r == 0 ? hold0 : hold1)) begin
          if (r == 0) v0 = ($urandom_range(0, 9) < 6);
          else        v1 = ($urandom_range(0, 9) < 6);
          px[r] = ($urandom_range(0, 9) == 0) ? $urandom_range(TH, 2047) : $urandom_range(0, TH + 2);
          py[r] = ($urandom_range(0, 9) == 0) ? $urandom_range(TV, 2047) : $urandom_range(0, TV + 2);
          pp[r] = $urandom_range(0, 255);
        end
      end
      bus.req0_valid = v0; bus.req0_x = 11'(px[0]); bus.req0_y = 11'(py[0]); bus.req0_pixel = 8'(pp[0]);
      bus.req1_valid = v1; bus.req1_x = 11'(px[1]); bus.req1_y = 11'(py[1]); bus.req1_pixel = 8'(pp[1]);
      #1;
      model_arb(v0, v1, g);
      n_total++;
      if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1))
        $display("FAIL rnd_grant c%0d: got r0=%b r1=%b want grant %0d", c, bus.req0_ready, bus.req1_ready, g);
      else n_pass++;
      hold0 = v0 && (g != 0);
      hold1 = v1 && (g != 1);
      exp_we = 0;
      if (g >= 0) begin
        if (px[g] < TH && py[g] < TV) exp_we = 1;
        else if (model_drop < DMAX) model_drop++;
      end
      @(posedge clk50);
      #1;
      n_total++;
      if (bus.pixel_write !== exp_we)
        $display("FAIL rnd_we c%0d: got %b want %b", c, bus.pixel_write, exp_we);
      else n_pass++;
      if (exp_we) begin
        n_total++;
        if (bus.x !== px[g] || bus.y !== py[g] || bus.pixel_GS !== pp[g])
          $display("FAIL rnd_data c%0d: got (%0d,%0d)=%0d want (%0d,%0d)=%0d", c, bus.x, bus.y, bus.pixel_GS, px[g], py[g], pp[g]);
        else n_pass++;
      end
      n_total++;
      if (bus.drop_count !== 4'(model_drop))
        $display("FAIL rnd_drop c%0d: got %0d want %0d", c, bus.drop_count, model_drop);
      else n_pass++;
    end
    @(negedge clk50);
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_alternate();
    test_drop();
    test_saturate();
    test_clear();
    test_clear_with_req();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
